// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the CPU-to-APB bridge.
package apb_bridge_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int STRB_W = DATA_W / 8;

  localparam int unsigned          TIMEOUT_DEF     = 16;
  localparam logic [DATA_W-1:0]    RD_ERR_DATA_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

endpackage

// File: rtl/apb_bridge_if.sv
// APB bus bundle. The bridge drives it through the master modport,
// a slave (or a bench posing as one) through the slave modport.
interface apb_bridge_if;
  import apb_bridge_pkg::*;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic              pready;
  logic              pslverr;
  logic [DATA_W-1:0] prdata;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, pslverr, prdata
  );

endinterface

// File: rtl/apb_bridge_wdog.sv
// Wait-state watchdog for the ACCESS phase. Counts cycles with pready low,
// saturates at LIMIT, and flags the cycle in which the count reaches LIMIT
// so the bridge can leave ACCESS on that same edge.
module apb_wdog #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int                CNT_W   = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0]  CNT_TC  = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise step up until saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // This waiting cycle is the one that brings the count to LIMIT
  assign expired = count && (cnt_q >= CNT_TC);

endmodule

// File: rtl/apb_bridge.sv
// Single-outstanding CPU-to-APB bridge with wait-state timeout.
//
// state  | meaning
// IDLE   | no transfer; trans_over=1, a cpu_wr/cpu_rd pulse is latched
// SETUP  | psel=1, penable=0; always one cycle
// ACCESS | psel=1, penable=1; wait for pready or watchdog expiry
module apb_bridge
  import apb_bridge_pkg::*;
#(
  parameter int unsigned       TIMEOUT     = TIMEOUT_DEF,
  parameter logic [DATA_W-1:0] RD_ERR_DATA = RD_ERR_DATA_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [STRB_W-1:0] cpu_byte,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_rdata_v,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              trans_over,
  output logic              err,
  apb_bridge_if.master      apb
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [STRB_W-1:0] byte_q, byte_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              pwrite_q, pwrite_d;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_v_q, rdata_v_d;
  logic              err_q, err_d;

  logic              psel, penable;
  logic              wd_clear, wd_count, wd_expired;
  logic [DATA_W-1:0] lane_mask;

  assign wd_clear = (state_q == SETUP);
  assign wd_count = (state_q == ACCESS) && !apb.pready;

  apb_wdog #(.LIMIT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .count   (wd_count),
    .expired (wd_expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; pready takes priority over a coincident expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu_wr || cpu_rd) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (apb.pready || wd_expired) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Expand byte enables into a bit mask for read data
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < STRB_W; i++) begin
      lane_mask[8*i +: 8] = {8{byte_q[i]}};
    end
  end

  // Bus phase outputs and completion strobes for the next cycle
  always_comb begin
    psel      = 1'b0;
    penable   = 1'b0;
    trans_over = 1'b0;
    rdata_v_d = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE:  trans_over = 1'b1;
      SETUP: psel = 1'b1;
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (apb.pready) begin
          err_d = apb.pslverr;
          if (!pwrite_q) begin
            rdata_v_d = 1'b1;
            rdata_d   = apb.pslverr ? RD_ERR_DATA : (apb.prdata & lane_mask);
          end
        end else if (wd_expired) begin
          err_d = 1'b1;
          if (!pwrite_q) begin
            rdata_v_d = 1'b1;
            rdata_d   = RD_ERR_DATA;
          end
        end
      end
      default: trans_over = 1'b0;
    endcase
  end

  // Capture a request only while idle; a write beats a simultaneous read
  always_comb begin
    addr_d   = addr_q;
    byte_d   = byte_q;
    wdata_d  = wdata_q;
    pwrite_d = pwrite_q;
    if ((state_q == IDLE) && (cpu_wr || cpu_rd)) begin
      addr_d   = cpu_addr;
      byte_d   = cpu_byte;
      wdata_d  = cpu_wdata;
      pwrite_d = cpu_wr;
    end
  end

  // Request and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      byte_q    <= '0;
      wdata_q   <= '0;
      pwrite_q  <= 1'b0;
      rdata_q   <= '0;
      rdata_v_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      byte_q    <= byte_d;
      wdata_q   <= wdata_d;
      pwrite_q  <= pwrite_d;
      rdata_q   <= rdata_d;
      rdata_v_q <= rdata_v_d;
      err_q     <= err_d;
    end
  end

  assign apb.psel    = psel;
  assign apb.penable = penable;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = addr_q;
  assign apb.pwdata  = wdata_q;
  assign apb.pstrb   = pwrite_q ? byte_q : '0;

  assign cpu_rdata_v = rdata_v_q;
  assign cpu_rdata   = rdata_q;
  assign err         = err_q;

endmodule

// File: tb/tb_apb_bridge.sv
// Bench for apb_bridge: reset values, a table of directed transfers,
// ignored requests, randomized transfers against a transaction-level model,
// and reset during ACCESS.
module tb_apb_bridge;
  import apb_bridge_pkg::*;

  localparam int          TMO  = 16;
  localparam logic [31:0] ERRD = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_wr, cpu_rd;
  logic [3:0]  cpu_byte, cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_rdata_v;
  logic [31:0] cpu_rdata;
  logic        trans_over, err;

  apb_bridge_if apb ();

  apb_bridge #(.TIMEOUT(TMO), .RD_ERR_DATA(ERRD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_wr      (cpu_wr),
    .cpu_rd      (cpu_rd),
    .cpu_byte    (cpu_byte),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata_v (cpu_rdata_v),
    .cpu_rdata   (cpu_rdata),
    .trans_over  (trans_over),
    .err         (err),
    .apb         (apb)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_rdata;

  typedef struct {
    logic        wr, rd;
    logic [3:0]  addr, byt;
    logic [31:0] wdata;
    int          waits;
    logic        slverr;
    logic [31:0] prdata;
    logic        exp_pwrite;
    logic [3:0]  exp_pstrb;
    int          exp_done;
    logic        exp_v;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        setup_ok, access_ok, stable;
    logic        pwrite;
    logic [3:0]  pstrb, paddr;
    logic [31:0] pwdata;
    int          done_at, v_cnt, v_at, err_cnt, err_at;
    logic [31:0] rdata;
    logic        bus_at_done;
  } obs_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level reference: outcome follows from wait count, error and lanes.
  function automatic vec_t model(input vec_t v, input logic [31:0] last_rdata);
    vec_t r = v;
    bit is_wr = v.wr;
    bit tmo = (v.waits >= TMO);
    logic [31:0] m;
    m = {{8{v.byt[3]}}, {8{v.byt[2]}}, {8{v.byt[1]}}, {8{v.byt[0]}}};
    r.exp_pwrite = is_wr;
    r.exp_pstrb  = is_wr ? v.byt : 4'h0;
    r.exp_done   = tmo ? TMO + 2 : v.waits + 3;
    r.exp_v      = !is_wr;
    r.exp_err    = tmo || v.slverr;
    if (is_wr)                r.exp_rdata = last_rdata;
    else if (tmo || v.slverr) r.exp_rdata = ERRD;
    else                      r.exp_rdata = v.prdata & m;
    return r;
  endfunction

  // Issue one request in the current cycle (called just after a negedge,
  // bridge idle) and act as the slave; returns at the negedge of the first
  // idle cycle after the transfer.
  task automatic run_txn(input vec_t v, input bit inj, output obs_t o);
    o = '{default: 0};
    o.done_at = -1;
    cpu_wr = v.wr; cpu_rd = v.rd; cpu_addr = v.addr; cpu_byte = v.byt; cpu_wdata = v.wdata;
    apb.pready = 1'b0; apb.pslverr = 1'b0; apb.prdata = $urandom;
    @(negedge clk);
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    cpu_addr = 4'($urandom); cpu_byte = 4'($urandom); cpu_wdata = $urandom;
    o.setup_ok = apb.psel && !apb.penable && !trans_over;
    o.pwrite = apb.pwrite; o.pstrb = apb.pstrb; o.paddr = apb.paddr; o.pwdata = apb.pwdata;
    o.stable = 1'b1; o.access_ok = 1'b1;
    if (inj) cpu_rd = 1'b1;
    for (int n = 2; n < 64; n++) begin
      @(negedge clk);
      cpu_wr = 1'b0; cpu_rd = 1'b0;
      if (cpu_rdata_v) begin o.v_cnt++; o.v_at = n; end
      if (err) begin o.err_cnt++; o.err_at = n; end
      if ({apb.pwrite, apb.pstrb, apb.paddr, apb.pwdata} !== {o.pwrite, o.pstrb, o.paddr, o.pwdata})
        o.stable = 1'b0;
      if (trans_over) begin
        o.done_at = n;
        o.rdata = cpu_rdata;
        o.bus_at_done = apb.psel | apb.penable;
        break;
      end
      if (!(apb.psel && apb.penable)) o.access_ok = 1'b0;
      if (inj && n == 2) begin cpu_wr = 1'b1; cpu_addr = ~v.addr; end
      apb.pready  = ((n - 2) == v.waits);
      apb.pslverr = apb.pready ? v.slverr : 1'($urandom);
      apb.prdata  = apb.pready ? v.prdata : $urandom;
    end
    apb.pready = 1'b0; apb.pslverr = 1'b0;
  endtask

  task automatic check_txn(input string tag, input vec_t v, input obs_t o);
    chk({tag, ".setup"},    32'(o.setup_ok), 32'd1);
    chk({tag, ".access"},   32'(o.access_ok), 32'd1);
    chk({tag, ".stable"},   32'(o.stable), 32'd1);
    chk({tag, ".pwrite"},   32'(o.pwrite), 32'(v.exp_pwrite));
    chk({tag, ".pstrb"},    32'(o.pstrb), 32'(v.exp_pstrb));
    chk({tag, ".paddr"},    32'(o.paddr), 32'(v.addr));
    chk({tag, ".pwdata"},   o.pwdata, v.wdata);
    chk({tag, ".done_at"},  32'(o.done_at), 32'(v.exp_done));
    chk({tag, ".bus_done"}, 32'(o.bus_at_done), 32'd0);
    chk({tag, ".v_cnt"},    32'(o.v_cnt), 32'(v.exp_v));
    if (v.exp_v) chk({tag, ".v_at"}, 32'(o.v_at), 32'(v.exp_done));
    chk({tag, ".err_cnt"},  32'(o.err_cnt), 32'(v.exp_err));
    if (v.exp_err) chk({tag, ".err_at"}, 32'(o.err_at), 32'(v.exp_done));
    chk({tag, ".rdata"},    o.rdata, v.exp_rdata);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    vec_t v;
    obs_t o;

    cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_byte = '0; cpu_addr = '0; cpu_wdata = '0;
    apb.pready = 1'b0; apb.pslverr = 1'b0; apb.prdata = '0;

    // Reset state
    @(negedge clk);
    chk("rst.trans_over", 32'(trans_over), 32'd1);
    chk("rst.psel_penable", 32'({apb.psel, apb.penable, apb.pwrite}), 32'd0);
    chk("rst.pstrb_paddr", 32'({apb.pstrb, apb.paddr}), 32'd0);
    chk("rst.pwdata", apb.pwdata, 32'd0);
    chk("rst.rdata_v_err", 32'({cpu_rdata_v, err}), 32'd0);
    chk("rst.cpu_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_rdata = 32'h0;

    // wr rd addr byte wdata waits slverr prdata | pwrite pstrb done v err rdata
    tbl[0] = '{1'b1, 1'b0, 4'h3, 4'hF, 32'hA5A5_1234,  0, 1'b0, 32'h0,          1'b1, 4'hF,  3, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 4'h5, 4'h5, 32'h0,          2, 1'b0, 32'h1122_3344,  1'b0, 4'h0,  5, 1'b1, 1'b0, 32'h0022_0044};
    tbl[2] = '{1'b0, 1'b1, 4'hA, 4'hF, 32'h0,         16, 1'b0, 32'h0,          1'b0, 4'h0, 18, 1'b1, 1'b1, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 4'h7, 4'h3, 32'hDEAD_BEEF,  1, 1'b0, 32'h0,          1'b1, 4'h3,  4, 1'b0, 1'b0, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 4'h2, 4'hF, 32'h0,          0, 1'b1, 32'hFFFF_FFFF,  1'b0, 4'h0,  3, 1'b1, 1'b1, 32'h0};
    tbl[5] = '{1'b1, 1'b0, 4'h9, 4'h8, 32'h1234_5678,  3, 1'b1, 32'h0,          1'b1, 4'h8,  6, 1'b0, 1'b1, 32'h0};
    tbl[6] = '{1'b0, 1'b1, 4'hC, 4'hA, 32'h0,         15, 1'b0, 32'hCAFE_BABE,  1'b0, 4'h0, 18, 1'b1, 1'b0, 32'hCA00_BA00};
    tbl[7] = '{1'b0, 1'b1, 4'h1, 4'h0, 32'h0,          0, 1'b0, 32'h1234_5678,  1'b0, 4'h0,  3, 1'b1, 1'b0, 32'h0};
    tbl[8] = '{1'b0, 1'b1, 4'hE, 4'hC, 32'h0,          1, 1'b0, 32'h89AB_CDEF,  1'b0, 4'h0,  4, 1'b1, 1'b0, 32'h89AB_0000};
    tbl[9] = '{1'b1, 1'b0, 4'h4, 4'h1, 32'h0000_00FF,  0, 1'b0, 32'h0,          1'b1, 4'h1,  3, 1'b0, 1'b0, 32'h89AB_0000};

    // Directed table, issued back to back
    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i], 1'b0, o);
      check_txn($sformatf("tbl%0d", i), tbl[i], o);
      model_rdata = tbl[i].exp_rdata;
    end

    // Requests during SETUP and ACCESS must be dropped, not queued
    v = '{1'b0, 1'b1, 4'h6, 4'hF, 32'h0, 3, 1'b0, 32'h0BAD_F00D, 1'b0, 4'h0, 0, 1'b0, 1'b0, 32'h0};
    v = model(v, model_rdata);
    run_txn(v, 1'b1, o);
    check_txn("ignore", v, o);
    model_rdata = v.exp_rdata;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ignore.no_queue", 32'({apb.psel, trans_over}), 32'b01);
    end

    // Randomized transfers against the reference model
    for (int k = 0; k < 40; k++) begin
      int op;
      int r;
      op = $urandom_range(0, 3);
      v.wr = (op == 0) || (op == 2);
      v.rd = (op != 0);
      v.addr = 4'($urandom); v.byt = 4'($urandom); v.wdata = $urandom; v.prdata = $urandom;
      r = $urandom_range(0, 9);
      v.waits = (r < 7) ? $urandom_range(0, 3) : $urandom_range(14, 17);
      v.slverr = ($urandom_range(0, 3) == 0);
      v = model(v, model_rdata);
      repeat ($urandom_range(0, 2)) begin
        apb.pready = 1'($urandom);
        @(negedge clk);
      end
      run_txn(v, 1'b0, o);
      check_txn($sformatf("rnd%0d", k), v, o);
      model_rdata = v.exp_rdata;
    end

    // Reset asserted in the middle of ACCESS
    cpu_rd = 1'b1; cpu_addr = 4'h5; cpu_byte = 4'hF; cpu_wdata = 32'h0;
    apb.pready = 1'b0;
    @(negedge clk);
    cpu_rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst.in_access", 32'({apb.psel, apb.penable}), 32'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst.bus", 32'({apb.psel, apb.penable, trans_over}), 32'b001);
    chk("mid_rst.strobes", 32'({cpu_rdata_v, err}), 32'd0);
    chk("mid_rst.paddr", 32'(apb.paddr), 32'd0);
    chk("mid_rst.cpu_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst.quiet", 32'({cpu_rdata_v, err, apb.psel, trans_over}), 32'b0001);
    end
    model_rdata = 32'h0;

    // Recovery after reset
    v = '{1'b0, 1'b1, 4'hB, 4'h3, 32'h0, 1, 1'b0, 32'hFEED_5A5A, 1'b0, 4'h0, 0, 1'b0, 1'b0, 32'h0};
    v = model(v, model_rdata);
    run_txn(v, 1'b0, o);
    check_txn("recover", v, o);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
